// File: rtl/hazard_control_unit_if.sv
// Bundle of the ID-stage hazard inputs and the pipeline-register control
// outputs of hazard_control_unit.
//   master : pipeline side, drives hazard inputs and observes control outputs
//   slave  : hazard_control_unit itself
// Handshake: none; every signal is sampled and produced every cycle. Control
// outputs are a same-cycle function of the inputs and the registered state.
interface hazard_control_unit_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_is_halt;
  logic [4:0] id_ex_rd;
  logic       id_ex_RW;
  logic       id_ex_mem_read;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_RW;
  logic [4:0] mem_wb_rd;
  logic       mem_wb_RW;
  logic       ex_is_mul;
  logic       ex_branch_taken;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_mem_bubble;
  logic       is_halted;
  logic [1:0] dbg_state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_halt,
           id_ex_rd, id_ex_RW, id_ex_mem_read, ex_mem_rd, ex_mem_RW,
           mem_wb_rd, mem_wb_RW, ex_is_mul, ex_branch_taken,
    input  pc_write, if_id_write, id_ex_write, if_id_flush,
           id_ex_bubble, ex_mem_bubble, is_halted, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_halt,
           id_ex_rd, id_ex_RW, id_ex_mem_read, ex_mem_rd, ex_mem_RW,
           mem_wb_rd, mem_wb_RW, ex_is_mul, ex_branch_taken,
    output pc_write, if_id_write, id_ex_write, if_id_flush,
           id_ex_bubble, ex_mem_bubble, is_halted, dbg_state
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the 5-stage RV32 core. Decides each
// cycle whether PC, IF/ID and ID/EX advance, hold or take a bubble: RAW
// stalls, taken-branch flushes, multi-cycle EX multiply and halt drain.
// Optional feature macro: FORWARDING_EN -- when defined only load-use
// hazards stall; otherwise any in-flight writer of a source register stalls.
// dbg_state exposes the FSM state (0 RUN, 1 MUL_BUSY, 2 DRAIN, 3 HALTED).
module hazard_control_unit #(
  parameter int MUL_LATENCY  = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hazard_control_unit_if.slave  bus
);

  localparam int MAX_CNT = (MUL_LATENCY > DRAIN_CYCLES) ? MUL_LATENCY : DRAIN_CYCLES;
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] MUL_INIT   = CW'(MUL_LATENCY - 2);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic w_match_ex_rs1, w_match_ex_rs2;
  logic w_raw;
  logic w_pc_write, w_if_id_write, w_id_ex_write;
  logic w_if_id_flush, w_id_ex_bubble, w_ex_mem_bubble, w_is_halted;

  // Source operand compare against the EX-stage destination; x0 never matches.
  assign w_match_ex_rs1 = bus.id_use_rs1 && (bus.id_rs1 != 5'd0) && (bus.id_ex_rd == bus.id_rs1);
  assign w_match_ex_rs2 = bus.id_use_rs2 && (bus.id_rs2 != 5'd0) && (bus.id_ex_rd == bus.id_rs2);

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; everything else bypasses.
  assign w_raw = bus.id_ex_mem_read && bus.id_ex_RW && (w_match_ex_rs1 || w_match_ex_rs2);
`else
  logic w_match_mem, w_match_wb;
  // Without bypassing, any older writer still in flight (including WB, since
  // the register file has no write-through) blocks the read in ID.
  assign w_match_mem = bus.ex_mem_RW &&
    ((bus.id_use_rs1 && (bus.id_rs1 != 5'd0) && (bus.ex_mem_rd == bus.id_rs1)) ||
     (bus.id_use_rs2 && (bus.id_rs2 != 5'd0) && (bus.ex_mem_rd == bus.id_rs2)));
  assign w_match_wb = bus.mem_wb_RW &&
    ((bus.id_use_rs1 && (bus.id_rs1 != 5'd0) && (bus.mem_wb_rd == bus.id_rs1)) ||
     (bus.id_use_rs2 && (bus.id_rs2 != 5'd0) && (bus.mem_wb_rd == bus.id_rs2)));
  assign w_raw = (bus.id_ex_RW && (w_match_ex_rs1 || w_match_ex_rs2)) || w_match_mem || w_match_wb;
`endif

  // State and counter update; reset drops straight back to RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.ex_is_mul) begin
            r_state <= MUL_BUSY;
            r_cnt   <= MUL_INIT;
          end else if (bus.ex_branch_taken || w_raw) begin
            r_state <= RUN;
          end else if (bus.id_is_halt) begin
            // The acceptance cycle itself is the first drain cycle.
            if (DRAIN_CYCLES == 1) begin
              r_state <= HALTED;
              r_cnt   <= '0;
            end else begin
              r_state <= DRAIN;
              r_cnt   <= DRAIN_INIT;
            end
          end
        end
        MUL_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DRAIN: begin
          // Leave on the count that makes is_halted rise exactly
          // DRAIN_CYCLES cycles after acceptance.
          if (r_cnt <= CW'(1)) begin
            r_state <= HALTED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= HALTED;
      endcase
    end
  end

  // Pipeline-register controls from current state plus same-cycle hazards.
  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_is_halted     = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.ex_is_mul) begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
          // Wrong-path instructions in IF/ID and ID are discarded.
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (w_raw || bus.id_is_halt) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        // Counter zero is the last multiply cycle: result moves on normally.
        if (r_cnt != '0) begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
        end
      end
      DRAIN: begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_bubble = 1'b1;
      end
      default: begin
        w_pc_write      = 1'b0;
        w_if_id_write   = 1'b0;
        w_id_ex_write   = 1'b0;
        w_if_id_flush   = 1'b1;
        w_id_ex_bubble  = 1'b1;
        w_ex_mem_bubble = 1'b1;
        w_is_halted     = 1'b1;
      end
    endcase
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.if_id_write   = w_if_id_write;
  assign bus.id_ex_write   = w_id_ex_write;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_bubble  = w_id_ex_bubble;
  assign bus.ex_mem_bubble = w_ex_mem_bubble;
  assign bus.is_halted     = w_is_halted;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MUL_LATENCY=4, DRAIN_CYCLES=3).
// Expected vector layout: {state[1:0], pc_write, if_id_write, id_ex_write,
// if_id_flush, id_ex_bubble, ex_mem_bubble, is_halted}.
module tb_hazard_control_unit;

  localparam int W = 9;

  // state RUN unless noted
  localparam logic [W-1:0] E_DEF    = {2'd0, 7'b1110000};
  localparam logic [W-1:0] E_STALL  = {2'd0, 7'b0010100};
  localparam logic [W-1:0] E_MULH   = {2'd0, 7'b0000010};
  localparam logic [W-1:0] E_MULB   = {2'd1, 7'b0000010};
  localparam logic [W-1:0] E_MULEND = {2'd1, 7'b1110000};
  localparam logic [W-1:0] E_BR     = {2'd0, 7'b1111100};
  localparam logic [W-1:0] E_DRAIN  = {2'd2, 7'b0010100};
  localparam logic [W-1:0] E_HALTED = {2'd3, 7'b0001111};

`ifdef FORWARDING_EN
  localparam logic [W-1:0] E_FWD_RAW = E_DEF;
`else
  localparam logic [W-1:0] E_FWD_RAW = E_STALL;
`endif

  logic clk;
  logic reset_n;

  hazard_control_unit_if bus ();

  hazard_control_unit #(
    .MUL_LATENCY (4),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests;
  int           n_fail;

  // driver tasks
  task automatic clr_inputs();
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.id_use_rs1      = 1'b0;
    bus.id_use_rs2      = 1'b0;
    bus.id_is_halt      = 1'b0;
    bus.id_ex_rd        = 5'd0;
    bus.id_ex_RW        = 1'b0;
    bus.id_ex_mem_read  = 1'b0;
    bus.ex_mem_rd       = 5'd0;
    bus.ex_mem_RW       = 1'b0;
    bus.mem_wb_rd       = 5'd0;
    bus.mem_wb_RW       = 1'b0;
    bus.ex_is_mul       = 1'b0;
    bus.ex_branch_taken = 1'b0;
  endtask

  // Start a new cycle: step past the edge, release reset, clear inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clr_inputs();
  endtask

  // Assert reset between edges so the return to RUN is seen with no clock.
  task automatic async_reset();
    @(posedge clk);
    #1;
    clr_inputs();
    reset_n = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.dbg_state, bus.pc_write, bus.if_id_write, bus.id_ex_write,
            bus.if_id_flush, bus.id_ex_bubble, bus.ex_mem_bubble, bus.is_halted};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", nm, a, e);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    clr_inputs();

    // reset state
    async_reset();
    expect_out("reset", E_DEF);
    cyc(); expect_out("idle", E_DEF);

    // ALU producer x6 walks EX -> MEM -> WB while ID reads x6
    cyc(); bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1; bus.id_ex_rd = 5'd6; bus.id_ex_RW = 1'b1;
    expect_out("raw_ex", E_FWD_RAW);
    cyc(); bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1; bus.ex_mem_rd = 5'd6; bus.ex_mem_RW = 1'b1;
    expect_out("raw_mem", E_FWD_RAW);
    cyc(); bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1; bus.mem_wb_rd = 5'd6; bus.mem_wb_RW = 1'b1;
    expect_out("raw_wb", E_FWD_RAW);
    cyc(); bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1;
    expect_out("raw_clear", E_DEF);

    // load x5 in EX, ID reads x5 on rs2: stalls in every build
    cyc(); bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1; bus.id_ex_rd = 5'd5;
    bus.id_ex_RW = 1'b1; bus.id_ex_mem_read = 1'b1;
    expect_out("load_use", E_STALL);
    cyc(); bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1; bus.ex_mem_rd = 5'd5; bus.ex_mem_RW = 1'b1;
    expect_out("load_use_next", E_FWD_RAW);
    // same pair but the EX instruction is not a load
    cyc(); bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1; bus.id_ex_rd = 5'd5; bus.id_ex_RW = 1'b1;
    expect_out("alu_use", E_FWD_RAW);

    // x0 never hazards, in any stage
    cyc(); bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
    bus.id_ex_RW = 1'b1; bus.id_ex_mem_read = 1'b1; bus.ex_mem_RW = 1'b1; bus.mem_wb_RW = 1'b1;
    expect_out("x0_no_stall", E_DEF);
    // source not actually read
    cyc(); bus.id_rs1 = 5'd7; bus.id_ex_rd = 5'd7; bus.id_ex_RW = 1'b1; bus.id_ex_mem_read = 1'b1;
    expect_out("unused_src", E_DEF);
    // load writes nothing (RW low)
    cyc(); bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1; bus.id_ex_rd = 5'd7; bus.id_ex_mem_read = 1'b1;
    expect_out("no_regwrite", E_DEF);

    // multiply outranks a load-use hazard; 3 hold cycles then release
    cyc(); bus.ex_is_mul = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    bus.id_ex_rd = 5'd5; bus.id_ex_RW = 1'b1; bus.id_ex_mem_read = 1'b1;
    expect_out("mul_c0", E_MULH);
    cyc(); bus.ex_is_mul = 1'b1; expect_out("mul_c1", E_MULB);
    cyc(); bus.ex_is_mul = 1'b1; expect_out("mul_c2", E_MULB);
    cyc(); bus.ex_is_mul = 1'b1; expect_out("mul_c3", E_MULEND);
    cyc(); expect_out("mul_after", E_DEF);

    // taken branch beats RAW stall and halt; no drain entered
    cyc(); bus.ex_branch_taken = 1'b1; bus.id_is_halt = 1'b1;
    bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_ex_rd = 5'd5;
    bus.id_ex_RW = 1'b1; bus.id_ex_mem_read = 1'b1;
    expect_out("branch", E_BR);
    cyc(); expect_out("branch_after", E_DEF);

    // RAW stall beats halt acceptance
    cyc(); bus.id_is_halt = 1'b1; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
    bus.id_ex_rd = 5'd9; bus.id_ex_RW = 1'b1; bus.id_ex_mem_read = 1'b1;
    expect_out("halt_blocked", E_STALL);

    // halt accepted; is_halted on the 3rd cycle after, then sticky
    cyc(); bus.id_is_halt = 1'b1; expect_out("halt_accept", E_STALL);
    cyc(); expect_out("drain_1", E_DRAIN);
    cyc(); expect_out("drain_2", E_DRAIN);
    cyc(); expect_out("halted_3", E_HALTED);
    cyc(); bus.ex_branch_taken = 1'b1; bus.ex_is_mul = 1'b1;
    expect_out("halted_sticky", E_HALTED);
    async_reset(); expect_out("reset_from_halt", E_DEF);
    cyc(); expect_out("run_after_reset", E_DEF);

    // reset in the middle of the drain
    cyc(); bus.id_is_halt = 1'b1; expect_out("halt_accept2", E_STALL);
    cyc(); expect_out("drain2_1", E_DRAIN);
    async_reset(); expect_out("reset_mid_drain", E_DEF);
    cyc(); expect_out("run_after_drain_reset", E_DEF);

    // reset in the middle of a multiply
    cyc(); bus.ex_is_mul = 1'b1; expect_out("mul2_c0", E_MULH);
    cyc(); bus.ex_is_mul = 1'b1; expect_out("mul2_c1", E_MULB);
    async_reset(); expect_out("reset_mid_mul", E_DEF);
    cyc(); expect_out("run_after_mul_reset", E_DEF);

    // let the monitor consume the last entries
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the 5-stage RV32 core: decides every cycle whether PC, IF/ID and ID/EX advance, hold, or take a bubble. Handles RAW stalls, taken-branch flushes, a multi-cycle EX multiply and the halt drain. Sits in ID beside the forwarding mux select logic and drives the pipeline-register write enables.

## Interface
- MUL_LATENCY, 4: EX cycles a multiply occupies (≥2)
- DRAIN_CYCLES, 3: cycles to retire older instructions after halt detection (≥1)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source
- id_is_halt  in  1  ID holds the halting ecall
- id_ex_rd  in  5  / id_ex_RW in 1 / id_ex_mem_read in 1  EX-stage destination, reg-write, load
- ex_mem_rd  in  5  / ex_mem_RW in 1  MEM-stage destination, reg-write
- mem_wb_rd  in  5  / mem_wb_RW in 1  WB-stage destination, reg-write
- ex_is_mul  in  1  EX holds a multiply
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- pc_write, if_id_write, id_ex_write  out  1 each  pipeline register enables
- if_id_flush, id_ex_bubble, ex_mem_bubble  out  1 each  insert NOP into that register
- is_halted  out  1  core stopped

## Operation
- States: RUN, MUL_BUSY, DRAIN, HALTED. Reset → RUN, counter 0.
- Outputs are combinational from state + inputs; state/counter registered.
- Default (RUN, no event): pc_write=if_id_write=id_ex_write=1, all flush/bubble=0, is_halted=0.
- RUN priority, highest first:
  1. ex_is_mul: hold PC, IF/ID, ID/EX (write=0), ex_mem_bubble=1; → MUL_BUSY, counter=MUL_LATENCY-2.
  2. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1 (overrides RAW stall and halt; wrong-path).
  3. RAW stall (below): pc_write=if_id_write=0, id_ex_bubble=1.
  4. id_is_halt: pc_write=if_id_write=0, id_ex_bubble=1; → DRAIN, counter=DRAIN_CYCLES-1.
- RAW match on source s: id_use_s && id_rs_s≠0 && rd==id_rs_s for a given stage.
- MUL_BUSY: counter>0 → same hold outputs, counter−1. counter==0 → final multiply cycle, default outputs (result enters EX/MEM), → RUN.
- DRAIN: pc_write=if_id_write=0, id_ex_bubble=1; counter−1 each cycle; at counter==0 → HALTED. No branch/mul can appear (halt only accepted with no mul in EX; younger slots are bubbles).
- HALTED: all write enables 0, bubbles 1, is_halted=1. Exit only by reset.
- Reset mid-MUL_BUSY or DRAIN: immediate return to RUN, counter 0.

## Timing
- RAW/branch/halt decisions: zero latency, same cycle as inputs.
- Multiply occupies EX exactly MUL_LATENCY cycles; ex_mem_bubble high for the first MUL_LATENCY-1.
- is_halted rises DRAIN_CYCLES cycles after the cycle id_is_halt was accepted.
- Load-use stall: exactly 1 cycle with forwarding compiled in.

## Configuration
- FORWARDING_EN defined: RAW stall only when id_ex_mem_read && id_ex_RW && match on id_ex_rd (load-use); forwarding unit covers the rest.
- Undefined: RAW stall when a match exists against id_ex_rd (id_ex_RW), ex_mem_rd (ex_mem_RW) or mem_wb_rd (mem_wb_RW); register file has no write-through, so WB matches stall.

## Test plan
- FORWARDING_EN: load x5 in EX, ID add reads x5 → 1 cycle pc_write=0, id_ex_bubble=1; next cycle defaults. Same with id_ex_mem_read=0 → no stall.
- No FORWARDING_EN: add x6 in EX, ID reads x6 → 3 stall cycles as producer moves EX→MEM→WB; rs=x0 matching rd=x0 → never stalls.
- ex_is_mul, MUL_LATENCY=4 → 3 cycles hold + ex_mem_bubble, 4th cycle defaults, state RUN.
- ex_branch_taken with RAW hazard and id_is_halt in ID → if_id_flush=1, id_ex_bubble=1, pc_write=1, no DRAIN entry.
- id_is_halt, DRAIN_CYCLES=3 → is_halted=1 on 3rd cycle after acceptance, stays high; reset_n low mid-DRAIN → RUN, is_halted=0 asynchronously.
